// File: rtl/maxnet_controller_if.sv
// Handshake and strobe bundle between the Maxnet control FSM and the
// surrounding logic/datapath.
interface maxnet_controller_if #(
  parameter int ITER_W = 4
) ();
  logic              start;
  logic              found;
  logic              main_write;
  logic              actWrite;
  logic              multWrite;
  logic              addWrite;
  logic              mainRegWrite;
  logic              s1;
  logic              s2;
  logic              s3;
  logic              s4;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [ITER_W-1:0] iter_count;

  modport master (
    input  start, found,
    output main_write, actWrite, multWrite, addWrite, mainRegWrite,
    output s1, s2, s3, s4, busy, done, timeout, iter_count
  );

  modport slave (
    output start, found,
    input  main_write, actWrite, multWrite, addWrite, mainRegWrite,
    input  s1, s2, s3, s4, busy, done, timeout, iter_count
  );
endinterface

// File: rtl/maxnet_controller.sv
// Moore control FSM sequencing the Maxnet datapath: load, repeated
// multiply/add/activate inhibition rounds, then result capture.
module maxnet_controller #(
  parameter int MAX_ITER = 15,
  parameter int ITER_W   = 4
) (
  input logic               clk,
  input logic               rst,
  maxnet_controller_if.master ctrl
);

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    INIT,
    MULT,
    ADD,
    ACT,
    CHECK,
    CAPTURE,
    DONE
  } state_t;

  localparam logic [ITER_W-1:0] MAX_CNT = ITER_W'(MAX_ITER);

  state_t            state;
  state_t            state_next;
  logic [ITER_W-1:0] iter_count;
  logic              timeout;
  logic              at_max;

  logic main_write;
  logic act_write;
  logic mult_write;
  logic add_write;
  logic main_reg_write;
  logic sel_b;
  logic busy;
  logic done;

  assign at_max = (iter_count == MAX_CNT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Iteration count and timeout persist past DONE so they can be read
  // after the run; only the next LOAD clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iter_count <= '0;
      timeout    <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          iter_count <= '0;
          timeout    <= 1'b0;
        end
        ACT: begin
          iter_count <= iter_count + ITER_W'(1);
        end
        CHECK: begin
          if (!ctrl.found && at_max) begin
            timeout <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ctrl.start) state_next = LOAD;
      LOAD:    state_next = INIT;
      INIT:    state_next = MULT;
      MULT:    state_next = ADD;
      ADD:     state_next = ACT;
      ACT:     state_next = CHECK;
      // A winner found on the last allowed round takes priority over timeout.
      CHECK: begin
        if (ctrl.found || at_max) begin
          state_next = CAPTURE;
        end else begin
          state_next = MULT;
        end
      end
      CAPTURE: state_next = DONE;
      DONE:    if (!ctrl.start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes and mux selects decode purely from the state register.
  always_comb begin
    main_write     = 1'b0;
    act_write      = 1'b0;
    mult_write     = 1'b0;
    add_write      = 1'b0;
    main_reg_write = 1'b0;
    sel_b          = 1'b0;
    busy           = 1'b1;
    done           = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
      end
      LOAD: begin
        main_write = 1'b1;
      end
      INIT: begin
        act_write = 1'b1;
      end
      MULT: begin
        mult_write = 1'b1;
        sel_b      = 1'b1;
      end
      ADD: begin
        add_write = 1'b1;
        sel_b     = 1'b1;
      end
      ACT: begin
        act_write = 1'b1;
        sel_b     = 1'b1;
      end
      CHECK: begin
        sel_b = 1'b1;
      end
      CAPTURE: begin
        main_reg_write = 1'b1;
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign ctrl.main_write   = main_write;
  assign ctrl.actWrite     = act_write;
  assign ctrl.multWrite    = mult_write;
  assign ctrl.addWrite     = add_write;
  assign ctrl.mainRegWrite = main_reg_write;
  assign ctrl.s1           = sel_b;
  assign ctrl.s2           = sel_b;
  assign ctrl.s3           = sel_b;
  assign ctrl.s4           = sel_b;
  assign ctrl.busy         = busy;
  assign ctrl.done         = done;
  assign ctrl.timeout      = timeout;
  assign ctrl.iter_count   = iter_count;

endmodule

// File: tb/tb_maxnet_controller.sv
// Directed bench for maxnet_controller: walks complete runs cycle by cycle
// and compares every output against hand-derived per-state values.
module tb_maxnet_controller;

  // Packed as {main_write, actWrite, multWrite, addWrite, mainRegWrite,
  //            s1, s2, s3, s4, busy, done}
  localparam logic [10:0] O_IDLE = 11'b0_0000_0000_00;
  localparam logic [10:0] O_LOAD = 11'b1_0000_0000_10;
  localparam logic [10:0] O_INIT = 11'b0_1000_0000_10;
  localparam logic [10:0] O_MULT = 11'b0_0100_1111_10;
  localparam logic [10:0] O_ADD  = 11'b0_0010_1111_10;
  localparam logic [10:0] O_ACT  = 11'b0_1000_1111_10;
  localparam logic [10:0] O_CHK  = 11'b0_0000_1111_10;
  localparam logic [10:0] O_CAP  = 11'b0_0001_0000_10;
  localparam logic [10:0] O_DONE = 11'b0_0000_0000_01;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  maxnet_controller_if #(.ITER_W(4)) bus ();

  maxnet_controller #(
    .MAX_ITER(15),
    .ITER_W  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ctrl(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic startIn, input logic foundIn);
    bus.start = startIn;
    bus.found = foundIn;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [10:0] expOuts,
                             input logic [3:0] expIter, input logic expTmo);
    logic [10:0] outs;
    outs = {bus.main_write, bus.actWrite, bus.multWrite, bus.addWrite,
            bus.mainRegWrite, bus.s1, bus.s2, bus.s3, bus.s4, bus.busy, bus.done};
    checks++;
    assert (outs === expOuts) else begin
      errors++;
      $error("FAIL %s outputs: observed=%b expected=%b", tag, outs, expOuts);
    end
    checks++;
    assert (bus.iter_count === expIter) else begin
      errors++;
      $error("FAIL %s iter_count: observed=%0d expected=%0d", tag, bus.iter_count, expIter);
    end
    checks++;
    assert (bus.timeout === expTmo) else begin
      errors++;
      $error("FAIL %s timeout: observed=%b expected=%b", tag, bus.timeout, expTmo);
    end
  endtask

  // One inhibition round, entered from INIT or a non-final CHECK and left in
  // CHECK; startJunk is pulsed during MULT to show start is ignored mid-run.
  task automatic runIter(input string tag, input logic [3:0] n, input logic startJunk);
    applyStimulus(startJunk, 1'b0);
    checkOutput({tag, " MULT"}, O_MULT, n - 4'd1, 1'b0);
    applyStimulus(startJunk, 1'b1);
    checkOutput({tag, " ADD"}, O_ADD, n - 4'd1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput({tag, " ACT"}, O_ACT, n - 4'd1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput({tag, " CHECK"}, O_CHK, n, 1'b0);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b0;
    bus.start = 1'b1;
    bus.found = 1'b0;

    // Reset held with start high: everything stays quiet.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("reset hold", O_IDLE, 4'd0, 1'b0);
    end
    rst = 1'b1;

    // Run A: winner at the first CHECK.
    applyStimulus(1'b1, 1'b0);
    checkOutput("A LOAD", O_LOAD, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("A INIT", O_INIT, 4'd0, 1'b0);
    runIter("A it1", 4'd1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("A CAPTURE", O_CAP, 4'd1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("A DONE", O_DONE, 4'd1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("A DONE held", O_DONE, 4'd1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("A IDLE", O_IDLE, 4'd1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("A IDLE stays", O_IDLE, 4'd1, 1'b0);

    // Run B: winner at the third CHECK, start toggled mid-run.
    applyStimulus(1'b1, 1'b0);
    checkOutput("B LOAD", O_LOAD, 4'd1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("B INIT", O_INIT, 4'd0, 1'b0);
    runIter("B it1", 4'd1, 1'b1);
    runIter("B it2", 4'd2, 1'b1);
    runIter("B it3", 4'd3, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("B CAPTURE", O_CAP, 4'd3, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("B DONE", O_DONE, 4'd3, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("B IDLE", O_IDLE, 4'd3, 1'b0);

    // Run C: no winner, times out after 15 rounds.
    applyStimulus(1'b1, 1'b0);
    checkOutput("C LOAD", O_LOAD, 4'd3, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("C INIT", O_INIT, 4'd0, 1'b0);
    for (int n = 1; n <= 15; n++) begin
      runIter("C iter", 4'(n), 1'b0);
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("C CAPTURE", O_CAP, 4'd15, 1'b1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("C DONE", O_DONE, 4'd15, 1'b1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("C IDLE", O_IDLE, 4'd15, 1'b1);

    // Run D: winner exactly at the final round beats timeout.
    applyStimulus(1'b1, 1'b0);
    checkOutput("D LOAD", O_LOAD, 4'd15, 1'b1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("D INIT", O_INIT, 4'd0, 1'b0);
    for (int n = 1; n <= 15; n++) begin
      runIter("D iter", 4'(n), 1'b0);
    end
    applyStimulus(1'b0, 1'b1);
    checkOutput("D CAPTURE", O_CAP, 4'd15, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("D DONE", O_DONE, 4'd15, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("D IDLE", O_IDLE, 4'd15, 1'b0);

    // Run E: reset dropped in the ADD of iteration 2.
    applyStimulus(1'b1, 1'b0);
    checkOutput("E LOAD", O_LOAD, 4'd15, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("E INIT", O_INIT, 4'd0, 1'b0);
    runIter("E it1", 4'd1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("E it2 MULT", O_MULT, 4'd1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("E it2 ADD", O_ADD, 4'd1, 1'b0);
    bus.start = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    checkOutput("E reset async", O_IDLE, 4'd0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("E reset held", O_IDLE, 4'd0, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0);
    checkOutput("E LOAD again", O_LOAD, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("E INIT again", O_INIT, 4'd0, 1'b0);
    runIter("E rerun it1", 4'd1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("E CAPTURE", O_CAP, 4'd1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("E DONE", O_DONE, 4'd1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/maxnet_controller.md
# maxnet_controller

Control FSM that sequences the Maxnet datapath through load, iterative inhibition and result capture. It drives the datapath's register write strobes and input-mux selects, samples its `found` flag once per iteration, and gives the surrounding logic a start/done handshake, a busy flag, an iteration count and a timeout indication. It sits beside the datapath in the top level; the two share a clock and reset.

## Interface
- `MAX_ITER`, default 15: maximum inhibition iterations before giving up; legal range 1 .. 2^ITER_W−1.
- `ITER_W`, default 4: width of the iteration counter.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `start`  in  1  level request; sampled only in IDLE and DONE.
- `found`  in  1  datapath "single winner remains" flag; sampled only in CHECK.
- `main_write`  out  1  load num1..num4 into the main registers.
- `actWrite`  out  1  write the activation registers.
- `multWrite`  out  1  write the epsilon-product registers.
- `addWrite`  out  1  write the sum registers.
- `mainRegWrite`  out  1  capture `max` into the result register.
- `s1`, `s2`, `s3`, `s4`  out  1 each  activation input-mux selects (0 = x, 1 = b); always equal.
- `busy`  out  1  high in every state except IDLE and DONE.
- `done`  out  1  result valid.
- `timeout`  out  1  last run ended at MAX_ITER without `found`.
- `iter_count`  out  ITER_W  completed iterations of the current/last run.

## Operation
- Moore FSM; states IDLE, LOAD, INIT, MULT, ADD, ACT, CHECK, CAPTURE, DONE. Strobes and selects decode from the state register only.
- IDLE: all strobes 0, selects 0. `start`=1 → LOAD.
- LOAD: `main_write`=1; `iter_count`←0; `timeout`←0. → INIT.
- INIT: `actWrite`=1, selects 0 (activations ← x). → MULT.
- MULT: `multWrite`=1, selects 1. → ADD.
- ADD: `addWrite`=1, selects 1. → ACT.
- ACT: `actWrite`=1, selects 1 (activations ← b); `iter_count`←`iter_count`+1. → CHECK.
- CHECK: no strobes, selects 1. `found`=1 → CAPTURE; else `iter_count`==MAX_ITER → CAPTURE with `timeout`←1; else → MULT.
- `found`=1 and `iter_count`==MAX_ITER in the same CHECK: `found` wins, `timeout` stays 0.
- CAPTURE: `mainRegWrite`=1 for exactly one cycle. → DONE.
- DONE: `done`=1; stays while `start`=1; `start`=0 → IDLE.
- `start` is ignored in LOAD..CAPTURE; a new run needs `start` low, then high (in DONE only the fall matters; in IDLE the level).
- `iter_count` and `timeout` are registers: hold their values through DONE and IDLE until the next LOAD. `iter_count` never exceeds MAX_ITER, so it never wraps.
- `found` is don't-care outside CHECK.

## Timing
- Reset (`rst`=0, asynchronous, any state): state → IDLE, `iter_count`=0, `timeout`=0. All outputs then read 0: strobes, selects, `busy`, `done`. Reset mid-run abandons the run; no strobe is issued after reset asserts.
- Leaving reset: first transition possible on the first rising edge with `rst`=1.
- `start` sampled high on edge 0 → LOAD in cycle 1, INIT 2, MULT 3, ADD 4, ACT 5, CHECK 6.
- Each extra iteration adds 4 cycles (MULT, ADD, ACT, CHECK).
- After N iterations: CAPTURE in cycle 4N+3, `done` first high in cycle 4N+4.
- Every strobe is high for exactly one cycle per visit. No two write strobes are ever high in the same cycle.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `start`=1 → all outputs 0, `iter_count`=0; release → LOAD on the next edge.
- `found`=1 at the first CHECK → `main_write` in cycle 1, `actWrite` in cycles 2 and 5, `multWrite` 3, `addWrite` 4, `mainRegWrite` 7, `done` from 8, `iter_count`=1, `timeout`=0.
- `found`=1 only at the third CHECK → `mainRegWrite` in cycle 15, `done` in 16, `iter_count`=3, selects 1 in cycles 3–14.
- `found` never asserted, MAX_ITER=15 → `timeout`=1, `iter_count`=15, `done` in cycle 64. A following run clears `timeout` in its LOAD.
- `found`=1 at iteration 15 with MAX_ITER=15 → `timeout`=0.
- `start` toggled during MULT/ADD → no effect. Holding `start`=1 in DONE keeps `done`=1; `start`=0 → IDLE next cycle.
- `rst` pulsed low during the ADD of iteration 2 → all outputs 0 immediately. After release with `start`=1 → a clean LOAD and `iter_count` restarting at 0.
